// File: rtl/ravenoc_pkg.sv
// Shared NoC definitions: flit type encodings, field positions, default sizing.
package ravenoc_pkg;

  localparam int unsigned DEF_FLIT_WIDTH   = 35;
  localparam int unsigned DEF_N_VIRT_CHN   = 2;
  localparam int unsigned DEF_BUFFER_DEPTH = 4;

  localparam int unsigned FLIT_TYPE_MSB = 34;
  localparam int unsigned FLIT_TYPE_LSB = 33;

  localparam logic [1:0] FLIT_HEAD      = 2'b00;
  localparam logic [1:0] FLIT_BODY      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  // Per-VC packet framing state: between packets or inside one
  typedef enum logic {
    FR_IDLE,
    FR_OPEN
  } frame_state_t;

endpackage

// File: rtl/vc_fifo.sv
// Single-VC synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module vc_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and count update; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port buffer: one FIFO per VC, framing checks, highest-VC-first output.
module vc_input_buffer
  import ravenoc_pkg::*;
#(
  parameter  int unsigned FLIT_WIDTH   = DEF_FLIT_WIDTH,
  parameter  int unsigned N_VIRT_CHN   = DEF_N_VIRT_CHN,
  parameter  int unsigned BUFFER_DEPTH = DEF_BUFFER_DEPTH,
  localparam int unsigned VC_W         = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1,
  localparam int unsigned CNT_W        = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          fin_valid_i,
  input  logic [VC_W-1:0]               fin_vc_id_i,
  input  logic [FLIT_WIDTH-1:0]         fin_flit_i,
  output logic [N_VIRT_CHN-1:0]         fin_ready_o,
  output logic                          fout_valid_o,
  output logic [VC_W-1:0]               fout_vc_id_o,
  output logic [FLIT_WIDTH-1:0]         fout_flit_o,
  input  logic [N_VIRT_CHN-1:0]         fout_ready_i,
  output logic [N_VIRT_CHN*CNT_W-1:0]   occupancy_o,
  output logic                          err_overflow_o,
  output logic                          err_framing_o
);

  logic [N_VIRT_CHN-1:0] wr_en;
  logic [N_VIRT_CHN-1:0] rd_en;
  logic [N_VIRT_CHN-1:0] full;
  logic [N_VIRT_CHN-1:0] empty;
  logic [CNT_W-1:0]      cnt     [N_VIRT_CHN];
  logic [FLIT_WIDTH-1:0] rd_data [N_VIRT_CHN];

  frame_state_t          fstate  [N_VIRT_CHN];
  frame_state_t          fnext   [N_VIRT_CHN];
  logic                  frame_err;
  logic                  accept;
  logic [1:0]            flit_type;

  logic                  sel_valid;
  logic [VC_W-1:0]       sel_vc;
  logic [FLIT_WIDTH-1:0] sel_flit;

  assign flit_type = fin_flit_i[FLIT_TYPE_MSB:FLIT_TYPE_LSB];
  assign accept    = |wr_en;

  for (genvar g = 0; g < N_VIRT_CHN; g++) begin : g_vc
    // Ready is held low asynchronously during reset; out-of-range ids match no VC
    assign fin_ready_o[g] = !full[g] && !arst;
    assign wr_en[g]       = fin_valid_i && (32'(fin_vc_id_i) == g) && fin_ready_o[g];
    assign rd_en[g]       = sel_valid && (sel_vc == VC_W'(g));
    assign occupancy_o[g*CNT_W +: CNT_W] = cnt[g];

    vc_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .wr_en   (wr_en[g]),
      .rd_en   (rd_en[g]),
      .wr_data (fin_flit_i),
      .rd_data (rd_data[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .count   (cnt[g])
    );
  end

  // Fixed-priority select: ascending scan so the highest eligible VC wins
  always_comb begin
    sel_valid = 1'b0;
    sel_vc    = '0;
    sel_flit  = '0;
    for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
      if (!arst && !empty[v] && fout_ready_i[v]) begin
        sel_valid = 1'b1;
        sel_vc    = VC_W'(v);
        sel_flit  = rd_data[v];
      end
    end
    fout_valid_o = sel_valid;
    fout_vc_id_o = sel_vc;
    fout_flit_o  = sel_flit;
  end

  // Framing next-state and violation detect, only for accepted pushes
  always_comb begin
    frame_err = 1'b0;
    for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
      fnext[v] = fstate[v];
      if (wr_en[v]) begin
        case (fstate[v])
          FR_IDLE: begin
            if (flit_type == FLIT_HEAD)           fnext[v] = FR_OPEN;
            else if (flit_type != FLIT_HEAD_TAIL) frame_err = 1'b1;
          end
          FR_OPEN: begin
            if (flit_type == FLIT_TAIL)           fnext[v] = FR_IDLE;
            else if (flit_type != FLIT_BODY)      frame_err = 1'b1;
          end
          default: fnext[v] = FR_IDLE;
        endcase
      end
    end
  end

  // Framing state registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned v = 0; v < N_VIRT_CHN; v++) fstate[v] <= FR_IDLE;
    end else begin
      for (int unsigned v = 0; v < N_VIRT_CHN; v++) fstate[v] <= fnext[v];
    end
  end

  // Sticky error flags; a valid flit not accepted means full or nonexistent VC
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_overflow_o <= 1'b0;
      err_framing_o  <= 1'b0;
    end else begin
      if (fin_valid_i && !accept) err_overflow_o <= 1'b1;
      if (frame_err)              err_framing_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer: vector table plus corner-case sequences.
module tb_vc_input_buffer;

  localparam logic [1:0] TH  = 2'b00;
  localparam logic [1:0] TB  = 2'b01;
  localparam logic [1:0] TT  = 2'b10;
  localparam logic [1:0] THT = 2'b11;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        fin_valid = 1'b0;
  logic        fin_vc = 1'b0;
  logic [34:0] fin_flit = '0;
  logic [1:0]  fin_ready;
  logic        fout_valid;
  logic        fout_vc;
  logic [34:0] fout_flit;
  logic [1:0]  fout_ready = 2'b00;
  logic [5:0]  occ;
  logic        err_ov;
  logic        err_fr;

  logic        v2 = 1'b0;
  logic [1:0]  vc2 = '0;
  logic [34:0] f2 = '0;
  logic [2:0]  rdy2 = '0;
  logic [2:0]  fin_ready2;
  logic        fout_valid2;
  logic [1:0]  fout_vc2;
  logic [34:0] fout_flit2;
  logic [8:0]  occ2;
  logic        err_ov2;
  logic        err_fr2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        valid;
    logic        vc;
    logic [34:0] flit;
    logic [1:0]  rdy;
    logic        e_valid;
    logic        e_vc;
    logic [34:0] e_flit;
    logic [1:0]  e_fin_ready;
    logic [5:0]  e_occ;
    logic        e_ov;
    logic        e_fr;
  } vec_t;

  vec_t vecs[$];

  vc_input_buffer dut (
    .clk            (clk),
    .arst           (arst),
    .fin_valid_i    (fin_valid),
    .fin_vc_id_i    (fin_vc),
    .fin_flit_i     (fin_flit),
    .fin_ready_o    (fin_ready),
    .fout_valid_o   (fout_valid),
    .fout_vc_id_o   (fout_vc),
    .fout_flit_o    (fout_flit),
    .fout_ready_i   (fout_ready),
    .occupancy_o    (occ),
    .err_overflow_o (err_ov),
    .err_framing_o  (err_fr)
  );

  vc_input_buffer #(.N_VIRT_CHN(3)) dut3 (
    .clk            (clk),
    .arst           (arst),
    .fin_valid_i    (v2),
    .fin_vc_id_i    (vc2),
    .fin_flit_i     (f2),
    .fin_ready_o    (fin_ready2),
    .fout_valid_o   (fout_valid2),
    .fout_vc_id_o   (fout_vc2),
    .fout_flit_o    (fout_flit2),
    .fout_ready_i   (rdy2),
    .occupancy_o    (occ2),
    .err_overflow_o (err_ov2),
    .err_framing_o  (err_fr2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [34:0] fl(input logic [1:0] t, input logic [7:0] p);
    return {t, 25'd0, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic valid, input logic vc, input logic [34:0] flit,
                     input logic [1:0] rdy, input logic ev, input logic evc,
                     input logic [34:0] eflit, input logic [1:0] efr,
                     input logic [5:0] eocc, input logic eov, input logic efrm);
    vecs.push_back('{valid, vc, flit, rdy, ev, evc, eflit, efr, eocc, eov, efrm});
  endtask

  task automatic do_reset();
    @(negedge clk);
    fin_valid = 1'b0;
    arst = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    // Cycle-by-cycle table: HEAD/BODY/TAIL flow, VC1 fill/overflow, priority
    add(1,0,fl(TH,8'h0A),2'b11, 0,0,'0,           2'b11, 0,0,0);
    add(1,0,fl(TB,8'h0B),2'b11, 1,0,fl(TH,8'h0A), 2'b11, 1,0,0);
    add(1,0,fl(TT,8'h0C),2'b11, 1,0,fl(TB,8'h0B), 2'b11, 1,0,0);
    add(0,0,'0,          2'b11, 1,0,fl(TT,8'h0C), 2'b11, 1,0,0);
    add(0,0,'0,          2'b11, 0,0,'0,           2'b11, 0,0,0);
    add(1,1,fl(TH,8'h10),2'b00, 0,0,'0,           2'b11, 0,0,0);
    add(1,1,fl(TB,8'h11),2'b00, 0,0,'0,           2'b11, 8,0,0);
    add(1,1,fl(TB,8'h12),2'b00, 0,0,'0,           2'b11, 16,0,0);
    add(1,1,fl(TT,8'h13),2'b00, 0,0,'0,           2'b11, 24,0,0);
    add(1,1,fl(TH,8'h14),2'b00, 0,0,'0,           2'b01, 32,0,0);
    add(1,0,fl(THT,8'h20),2'b00,0,0,'0,           2'b01, 32,1,0);
    add(1,0,fl(THT,8'h21),2'b01,1,0,fl(THT,8'h20),2'b01, 33,1,0);
    add(0,0,'0,          2'b11, 1,1,fl(TH,8'h10), 2'b01, 33,1,0);
    add(0,0,'0,          2'b11, 1,1,fl(TB,8'h11), 2'b11, 25,1,0);
    add(0,0,'0,          2'b11, 1,1,fl(TB,8'h12), 2'b11, 17,1,0);
    add(0,0,'0,          2'b11, 1,1,fl(TT,8'h13), 2'b11, 9,1,0);
    add(0,0,'0,          2'b11, 1,0,fl(THT,8'h21),2'b11, 1,1,0);
    add(0,0,'0,          2'b11, 0,0,'0,           2'b11, 0,1,0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.fout_valid", 64'(fout_valid), 64'(0));
    chk("rst.fin_ready",  64'(fin_ready),  64'(0));
    chk("rst.occ",        64'(occ),        64'(0));
    chk("rst.err_ov",     64'(err_ov),     64'(0));
    chk("rst.err_fr",     64'(err_fr),     64'(0));
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("rel.fin_ready",  64'(fin_ready),  64'(2'b11));
    chk("rel.fout_valid", 64'(fout_valid), 64'(0));

    foreach (vecs[i]) begin
      @(negedge clk);
      fin_valid  = vecs[i].valid;
      fin_vc     = vecs[i].vc;
      fin_flit   = vecs[i].flit;
      fout_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d.fout_valid", i), 64'(fout_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d.fout_vc", i),    64'(fout_vc),    64'(vecs[i].e_vc));
      chk($sformatf("v%0d.fout_flit", i),  64'(fout_flit),  64'(vecs[i].e_flit));
      chk($sformatf("v%0d.fin_ready", i),  64'(fin_ready),  64'(vecs[i].e_fin_ready));
      chk($sformatf("v%0d.occ", i),        64'(occ),        64'(vecs[i].e_occ));
      chk($sformatf("v%0d.err_ov", i),     64'(err_ov),     64'(vecs[i].e_ov));
      chk($sformatf("v%0d.err_fr", i),     64'(err_fr),     64'(vecs[i].e_fr));
    end

    // BODY while IDLE is a framing error but the flit is still stored
    do_reset();
    fin_valid = 1'b1; fin_vc = 1'b0; fin_flit = fl(TB, 8'h2A); fout_ready = 2'b11;
    #1;
    chk("bodyidle.err_fr_before", 64'(err_fr), 64'(0));
    @(negedge clk);
    fin_valid = 1'b0;
    #1;
    chk("bodyidle.err_fr",    64'(err_fr),    64'(1));
    chk("bodyidle.flit",      64'(fout_flit), 64'(fl(TB, 8'h2A)));

    // HEAD then HEAD: error flagged, both delivered in order
    do_reset();
    #1;
    chk("hh.err_fr_cleared", 64'(err_fr), 64'(0));
    fin_valid = 1'b1; fin_vc = 1'b0; fin_flit = fl(TH, 8'h30);
    @(negedge clk);
    fin_flit = fl(TH, 8'h31);
    #1;
    chk("hh.first", 64'(fout_flit), 64'(fl(TH, 8'h30)));
    @(negedge clk);
    fin_valid = 1'b0;
    #1;
    chk("hh.second", 64'(fout_flit), 64'(fl(TH, 8'h31)));
    chk("hh.err_fr", 64'(err_fr),    64'(1));

    // Reset mid-packet with three flits buffered
    do_reset();
    fout_ready = 2'b00;
    fin_valid = 1'b1; fin_vc = 1'b0; fin_flit = fl(TH, 8'h40);
    @(negedge clk); fin_flit = fl(TB, 8'h41);
    @(negedge clk); fin_flit = fl(TB, 8'h42);
    @(negedge clk);
    fin_valid = 1'b0; fout_ready = 2'b11;
    #1;
    chk("mid.valid_pre", 64'(fout_valid), 64'(1));
    chk("mid.occ_pre",   64'(occ),        64'(3));
    arst = 1'b1;
    #1;
    chk("mid.valid_rst",     64'(fout_valid), 64'(0));
    chk("mid.fin_ready_rst", 64'(fin_ready),  64'(0));
    chk("mid.occ_rst",       64'(occ),        64'(0));
    repeat (2) @(negedge clk);
    arst = 1'b0;
    #1;
    chk("mid.occ_rel",       64'(occ),        64'(0));
    chk("mid.fin_ready_rel", 64'(fin_ready),  64'(2'b11));
    chk("mid.valid_rel",     64'(fout_valid), 64'(0));
    fin_valid = 1'b1; fin_vc = 1'b0; fin_flit = fl(TH, 8'h43);
    @(negedge clk);
    fin_valid = 1'b0;
    #1;
    chk("mid.new_head", 64'(fout_flit), 64'(fl(TH, 8'h43)));
    chk("mid.err_fr",   64'(err_fr),    64'(0));

    // Nonexistent VC id on a 3-VC instance: dropped, overflow flagged
    @(negedge clk);
    v2 = 1'b1; vc2 = 2'd1; f2 = fl(TH, 8'h50); rdy2 = 3'b000;
    @(negedge clk);
    vc2 = 2'd3; f2 = fl(TH, 8'h51);
    #1;
    chk("bad_vc.occ_before", 64'(occ2),    64'(9'd8));
    chk("bad_vc.ov_before",  64'(err_ov2), 64'(0));
    @(negedge clk);
    v2 = 1'b0;
    #1;
    chk("bad_vc.occ_after",  64'(occ2),       64'(9'd8));
    chk("bad_vc.ov_after",   64'(err_ov2),    64'(1));
    chk("bad_vc.fin_ready",  64'(fin_ready2), 64'(3'b111));
    chk("bad_vc.err_fr",     64'(err_fr2),    64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
